// File: rtl/reorder_buffer.sv
// In-order retirement queue: dispatch allocates at the tail, the CDB completes
// entries, and the head retires in program order. Also serves operand lookups.
module reorder_buffer #(
   parameter int DEPTH = 32,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             alloc_valid,
   input  logic [2:0]       alloc_op_type,
   input  logic [4:0]       alloc_rd_addr,
   input  logic             alloc_regf_we,
   output logic             alloc_ready,
   output logic [IDX_W-1:0] alloc_rob_idx,
   input  logic             cdb_valid,
   input  logic [IDX_W-1:0] cdb_rob_idx,
   input  logic [31:0]      cdb_data,
   input  logic [IDX_W-1:0] rs1_rob_idx,
   output logic             rs1_rob_ready,
   output logic [31:0]      rs1_rob_data,
   input  logic [IDX_W-1:0] rs2_rob_idx,
   output logic             rs2_rob_ready,
   output logic [31:0]      rs2_rob_data,
   output logic             commit_valid,
   input  logic             commit_ready,
   output logic [IDX_W-1:0] commit_rob_idx,
   output logic [4:0]       commit_rd_addr,
   output logic [31:0]      commit_rd_data,
   output logic             commit_regf_we,
   output logic [IDX_W:0]   count
);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_WAIT,
      ST_DONE
   } status_t;

   typedef struct packed {
      logic        valid;
      status_t     status;
      logic [2:0]  op_type;
      logic [4:0]  rd_addr;
      logic [31:0] rd_data;
      logic        regf_we;
   } rob_entry_t;

   rob_entry_t       rob_q [DEPTH];
   logic [IDX_W:0]   head_q;
   logic [IDX_W:0]   tail_q;
   logic [IDX_W:0]   count_q;

   rob_entry_t       head_e;
   rob_entry_t       cdb_e;
   logic             empty;
   logic             full;
   logic             do_alloc;
   logic             do_commit;
   logic             cdb_hit;
   logic [2:0]       unused_op_type;

   // Wrap the index part at DEPTH and toggle the lap bit.
   function automatic logic [IDX_W:0] ptr_inc(input logic [IDX_W:0] p);
      logic [IDX_W:0] r;
      if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1))
         r = {~p[IDX_W], {IDX_W{1'b0}}};
      else
         r = p + 1'b1;
      return r;
   endfunction

   function automatic logic [32:0] lookup(
      input rob_entry_t       e,
      input logic [IDX_W-1:0] idx
   );
      logic [32:0] r;
      r = '0;
      if (e.valid && e.status == ST_DONE)
         r = {1'b1, e.rd_data};
      else if (e.valid && e.status == ST_WAIT &&
               cdb_valid && cdb_rob_idx == idx)
         r = {1'b1, cdb_data};
      return r;
   endfunction

   assign head_e = rob_q[head_q[IDX_W-1:0]];
   assign cdb_e  = rob_q[cdb_rob_idx];

   assign empty = (head_q == tail_q);
   assign full  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                  (head_q[IDX_W] != tail_q[IDX_W]);

   assign alloc_ready   = ~full;
   assign alloc_rob_idx = tail_q[IDX_W-1:0];
   assign count         = count_q;

   assign commit_valid   = ~empty & head_e.valid &
                           (head_e.status == ST_DONE);
   assign commit_rob_idx = head_q[IDX_W-1:0];
   assign commit_rd_addr = head_e.rd_addr;
   assign commit_rd_data = head_e.rd_data;
   assign commit_regf_we = head_e.regf_we;
   assign unused_op_type = head_e.op_type;

   assign do_alloc  = alloc_valid & ~full;
   assign do_commit = commit_valid & commit_ready;
   assign cdb_hit   = cdb_valid & cdb_e.valid & (cdb_e.status == ST_WAIT);

   always_comb begin
      {rs1_rob_ready, rs1_rob_data} = lookup(rob_q[rs1_rob_idx], rs1_rob_idx);
      {rs2_rob_ready, rs2_rob_data} = lookup(rob_q[rs2_rob_idx], rs2_rob_idx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rob_q[i]        <= '0;
            rob_q[i].status <= ST_EMPTY;
         end
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rob_q[i]        <= '0;
            rob_q[i].status <= ST_EMPTY;
         end
      end else begin
         if (do_commit) begin
            rob_q[head_q[IDX_W-1:0]].valid  <= 1'b0;
            rob_q[head_q[IDX_W-1:0]].status <= ST_EMPTY;
            head_q <= ptr_inc(head_q);
         end
         if (do_alloc) begin
            rob_q[tail_q[IDX_W-1:0]].valid   <= 1'b1;
            rob_q[tail_q[IDX_W-1:0]].status  <= ST_WAIT;
            rob_q[tail_q[IDX_W-1:0]].op_type <= alloc_op_type;
            rob_q[tail_q[IDX_W-1:0]].rd_addr <= alloc_rd_addr;
            rob_q[tail_q[IDX_W-1:0]].rd_data <= '0;
            rob_q[tail_q[IDX_W-1:0]].regf_we <= alloc_regf_we;
            tail_q <= ptr_inc(tail_q);
         end
         // Stale or flushed tags miss the ST_WAIT check and are dropped.
         if (cdb_hit) begin
            rob_q[cdb_rob_idx].rd_data <= cdb_data;
            rob_q[cdb_rob_idx].status  <= ST_DONE;
         end
         unique case ({do_alloc, do_commit})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: alloc/complete/commit ordering, full and
// wrap, CDB bypass on lookup, flush, and asynchronous reset.
module tb_reorder_buffer;

   localparam int DEPTH = 32;
   localparam int IDX_W = 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic             alloc_valid;
   logic [2:0]       alloc_op_type;
   logic [4:0]       alloc_rd_addr;
   logic             alloc_regf_we;
   logic             alloc_ready;
   logic [IDX_W-1:0] alloc_rob_idx;
   logic             cdb_valid;
   logic [IDX_W-1:0] cdb_rob_idx;
   logic [31:0]      cdb_data;
   logic [IDX_W-1:0] rs1_rob_idx;
   logic             rs1_rob_ready;
   logic [31:0]      rs1_rob_data;
   logic [IDX_W-1:0] rs2_rob_idx;
   logic             rs2_rob_ready;
   logic [31:0]      rs2_rob_data;
   logic             commit_valid;
   logic             commit_ready;
   logic [IDX_W-1:0] commit_rob_idx;
   logic [4:0]       commit_rd_addr;
   logic [31:0]      commit_rd_data;
   logic             commit_regf_we;
   logic [IDX_W:0]   count;

   int total = 0;
   int bad   = 0;

   reorder_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .alloc_valid    (alloc_valid),
      .alloc_op_type  (alloc_op_type),
      .alloc_rd_addr  (alloc_rd_addr),
      .alloc_regf_we  (alloc_regf_we),
      .alloc_ready    (alloc_ready),
      .alloc_rob_idx  (alloc_rob_idx),
      .cdb_valid      (cdb_valid),
      .cdb_rob_idx    (cdb_rob_idx),
      .cdb_data       (cdb_data),
      .rs1_rob_idx    (rs1_rob_idx),
      .rs1_rob_ready  (rs1_rob_ready),
      .rs1_rob_data   (rs1_rob_data),
      .rs2_rob_idx    (rs2_rob_idx),
      .rs2_rob_ready  (rs2_rob_ready),
      .rs2_rob_data   (rs2_rob_data),
      .commit_valid   (commit_valid),
      .commit_ready   (commit_ready),
      .commit_rob_idx (commit_rob_idx),
      .commit_rd_addr (commit_rd_addr),
      .commit_rd_data (commit_rd_data),
      .commit_regf_we (commit_regf_we),
      .count          (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alloc_one(input logic [4:0] rd, input logic we,
                            input logic [IDX_W-1:0] exp_idx);
      alloc_valid   = 1'b1;
      alloc_rd_addr = rd;
      alloc_regf_we = we;
      alloc_op_type = 3'd1;
      #1;
      chk("alloc_idx", 32'(alloc_rob_idx), 32'(exp_idx));
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic cdb_one(input logic [IDX_W-1:0] idx, input logic [31:0] d);
      cdb_valid   = 1'b1;
      cdb_rob_idx = idx;
      cdb_data    = d;
      tick();
      cdb_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      alloc_valid = 1'b0;
      alloc_op_type = '0;
      alloc_rd_addr = '0;
      alloc_regf_we = 1'b0;
      cdb_valid = 1'b0;
      cdb_rob_idx = '0;
      cdb_data = '0;
      rs1_rob_idx = '0;
      rs2_rob_idx = '0;
      commit_ready = 1'b0;
      #2;
      chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
      chk("rst_alloc_idx", 32'(alloc_rob_idx), 32'd0);
      chk("rst_commit_valid", 32'(commit_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_rs1_ready", 32'(rs1_rob_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // three allocations, nothing done yet
      alloc_one(5'd1, 1'b1, 5'd0);
      alloc_one(5'd2, 1'b1, 5'd1);
      alloc_one(5'd3, 1'b0, 5'd2);
      chk("t1_count", 32'(count), 32'd3);
      chk("t1_commit_valid", 32'(commit_valid), 32'd0);

      // out-of-order completion, in-order commit
      cdb_one(5'd1, 32'hAA);
      chk("t2_young_done", 32'(commit_valid), 32'd0);
      cdb_one(5'd0, 32'h55);
      chk("t2_cv0", 32'(commit_valid), 32'd1);
      chk("t2_idx0", 32'(commit_rob_idx), 32'd0);
      chk("t2_rd0", 32'(commit_rd_addr), 32'd1);
      chk("t2_data0", commit_rd_data, 32'h55);
      chk("t2_we0", 32'(commit_regf_we), 32'd1);
      commit_ready = 1'b1;
      tick();
      chk("t2_cv1", 32'(commit_valid), 32'd1);
      chk("t2_idx1", 32'(commit_rob_idx), 32'd1);
      chk("t2_data1", commit_rd_data, 32'hAA);
      chk("t2_rd1", 32'(commit_rd_addr), 32'd2);
      tick();
      commit_ready = 1'b0;
      chk("t2_idx2_blocked", 32'(commit_valid), 32'd0);
      chk("t2_count", 32'(count), 32'd1);
      cdb_one(5'd2, 32'h3C);
      chk("t2_idx2_cv", 32'(commit_valid), 32'd1);
      chk("t2_idx2_we", 32'(commit_regf_we), 32'd0);

      // clear via flush, then fill to full
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         alloc_one(5'(i), 1'b1, 5'(i));
      chk("t3_ready_full", 32'(alloc_ready), 32'd0);
      chk("t3_count_full", 32'(count), 32'd32);
      chk("t3_tail_wrap", 32'(alloc_rob_idx), 32'd0);
      alloc_valid = 1'b1;
      alloc_rd_addr = 5'd9;
      tick();
      alloc_valid = 1'b0;
      chk("t3_drop_count", 32'(count), 32'd32);
      cdb_one(5'd0, 32'hC0);
      chk("t3_head_cv", 32'(commit_valid), 32'd1);
      commit_ready = 1'b1;
      alloc_valid = 1'b1;
      tick();
      commit_ready = 1'b0;
      alloc_valid = 1'b0;
      chk("t3_no_same_cyc", 32'(count), 32'd31);
      chk("t3_ready_again", 32'(alloc_ready), 32'd1);
      alloc_one(5'd5, 1'b1, 5'd0);
      chk("t3_refull", 32'(alloc_ready), 32'd0);

      // CDB bypass on lookup
      rs1_rob_idx = 5'd4;
      rs2_rob_idx = 5'd5;
      cdb_valid = 1'b1;
      cdb_rob_idx = 5'd4;
      cdb_data = 32'h1234;
      #1;
      chk("t4_byp_ready", 32'(rs1_rob_ready), 32'd1);
      chk("t4_byp_data", rs1_rob_data, 32'h1234);
      chk("t4_rs2_ready", 32'(rs2_rob_ready), 32'd0);
      chk("t4_rs2_data", rs2_rob_data, 32'd0);
      tick();
      cdb_valid = 1'b0;
      #1;
      chk("t4_done_ready", 32'(rs1_rob_ready), 32'd1);
      chk("t4_done_data", rs1_rob_data, 32'h1234);
      cdb_one(5'd4, 32'h9999);
      chk("t4_stale_data", rs1_rob_data, 32'h1234);

      // alloc + CDB + commit on distinct entries
      cdb_one(5'd1, 32'h11);
      chk("t5_cv1_data", commit_rd_data, 32'h11);
      commit_ready = 1'b1;
      cdb_one(5'd2, 32'h22);
      chk("t5_cv2", 32'(commit_valid), 32'd1);
      chk("t5_cv2_data", commit_rd_data, 32'h22);
      chk("t5_aidx", 32'(alloc_rob_idx), 32'd1);
      alloc_valid = 1'b1;
      alloc_rd_addr = 5'd7;
      cdb_one(5'd3, 32'h33);
      alloc_valid = 1'b0;
      commit_ready = 1'b0;
      chk("t5_count_net0", 32'(count), 32'd31);
      chk("t5_head3", 32'(commit_rob_idx), 32'd3);
      chk("t5_head3_data", commit_rd_data, 32'h33);
      chk("t5_head3_rd", 32'(commit_rd_addr), 32'd3);
      chk("t5_aidx2", 32'(alloc_rob_idx), 32'd2);

      // flush wins over alloc, CDB and commit
      flush = 1'b1;
      alloc_valid = 1'b1;
      cdb_valid = 1'b1;
      cdb_rob_idx = 5'd5;
      commit_ready = 1'b1;
      tick();
      flush = 1'b0;
      alloc_valid = 1'b0;
      cdb_valid = 1'b0;
      commit_ready = 1'b0;
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_cv", 32'(commit_valid), 32'd0);
      chk("t6_aidx", 32'(alloc_rob_idx), 32'd0);
      chk("t6_aready", 32'(alloc_ready), 32'd1);
      rs1_rob_idx = 5'd3;
      cdb_valid = 1'b1;
      cdb_rob_idx = 5'd3;
      cdb_data = 32'h77;
      #1;
      chk("t6_stale_byp", 32'(rs1_rob_ready), 32'd0);
      chk("t6_stale_data", rs1_rob_data, 32'd0);
      tick();
      cdb_valid = 1'b0;
      #1;
      chk("t6_stale_after", 32'(rs1_rob_ready), 32'd0);
      chk("t6_count_after", 32'(count), 32'd0);

      // asynchronous reset between edges
      alloc_one(5'd9, 1'b1, 5'd0);
      cdb_one(5'd0, 32'hABCD);
      rs1_rob_idx = 5'd0;
      #1;
      chk("t7_pre_cv", 32'(commit_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t7_cv", 32'(commit_valid), 32'd0);
      chk("t7_count", 32'(count), 32'd0);
      chk("t7_aready", 32'(alloc_ready), 32'd1);
      chk("t7_aidx", 32'(alloc_rob_idx), 32'd0);
      chk("t7_rs1", 32'(rs1_rob_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      alloc_one(5'd4, 1'b1, 5'd0);
      chk("t7_count_post", 32'(count), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
